// File: rtl/aes_input_loader_if.sv
// Byte-stream port of the AES input loader: one byte per handshake, plus the
// per-frame key flag that is only looked at on a frame's first byte.
interface aes_input_loader_if;
    // A byte moves on a rising edge where byte_valid && byte_ready; the source
    // holds byte_in/byte_valid until then, and byte_ready never depends on byte_valid.
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       load_key;

    modport master (output byte_in, output byte_valid, output load_key, input byte_ready);
    modport slave  (input byte_in, input byte_valid, input load_key, output byte_ready);
endinterface

// File: rtl/aes_input_loader.sv
// Byte-serial front end for the iterative AES core: assembles key and plaintext,
// drives the core's reset and flags when the core's state holds the ciphertext.
module aes_input_loader #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    aes_input_loader_if.slave      stream,
    input  logic                   abort,
    input  logic                   done_ack,
    output logic [32*Nk-1:0]       key_out,
    output logic [127:0]           block_out,
    output logic                   core_rst,
    output logic                   done,
    output logic [2:0]             dbg_state
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD_KEY = 3'd1;
    localparam logic [2:0] LOAD_PT  = 3'd2;
    localparam logic [2:0] RUN      = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam int              KW       = 32 * Nk;
    localparam logic [5:0]      key_last = 6'(4 * Nk - 1);
    localparam logic [5:0]      pt_last  = 6'd15;
    localparam int              RW       = $clog2(Nr + 1);
    localparam logic [RW-1:0]   run_last = RW'(Nr);

    logic [2:0]    state;
    logic [5:0]    byte_cnt;
    logic [RW-1:0] run_cnt;
    logic [KW-1:0] key_sh;
    logic [127:0]  pt_sh;
    logic [KW-1:0] key_next;
    logic [127:0]  pt_next;
    logic          take;

    assign stream.byte_ready = (state == IDLE) || (state == LOAD_KEY) || (state == LOAD_PT);
    assign take              = stream.byte_valid && stream.byte_ready;
    assign done              = (state == DONE);
    assign dbg_state         = state;

    // First byte of a field ends up in the MSB after the field's last shift.
    assign key_next = {key_sh[KW-9:0], stream.byte_in};
    assign pt_next  = {pt_sh[119:0], stream.byte_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            run_cnt   <= '0;
            key_sh    <= '0;
            pt_sh     <= '0;
            key_out   <= '0;
            block_out <= '0;
            core_rst  <= 1'b1;
        end else if (abort) begin
            // Outputs are only written on field completion, so a partial field never leaks.
            state    <= IDLE;
            byte_cnt <= '0;
            run_cnt  <= '0;
            core_rst <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        byte_cnt <= 6'd1;
                        if (stream.load_key) begin
                            key_sh <= key_next;
                            state  <= LOAD_KEY;
                        end else begin
                            pt_sh <= pt_next;
                            state <= LOAD_PT;
                        end
                    end
                end
                LOAD_KEY: begin
                    if (take) begin
                        key_sh <= key_next;
                        if (byte_cnt == key_last) begin
                            key_out  <= key_next;
                            byte_cnt <= '0;
                            state    <= LOAD_PT;
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                        end
                    end
                end
                LOAD_PT: begin
                    if (take) begin
                        pt_sh <= pt_next;
                        if (byte_cnt == pt_last) begin
                            block_out <= pt_next;
                            byte_cnt  <= '0;
                            run_cnt   <= '0;
                            core_rst  <= 1'b0;
                            state     <= RUN;
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                        end
                    end
                end
                RUN: begin
                    // Core needs Nr+1 edges out of reset before its state is the ciphertext.
                    if (run_cnt == run_last) begin
                        state <= DONE;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (done_ack) begin
                        state    <= IDLE;
                        run_cnt  <= '0;
                        core_rst <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    byte_cnt <= '0;
                    run_cnt  <= '0;
                    core_rst <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_input_loader.sv
// Bench for aes_input_loader: an AES-128 and an AES-256 loader side by side,
// checked every cycle against a frame-level model plus literal expectations.
module tb_aes_input_loader;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [7:0]   b_in[2];
    logic         b_valid[2];
    logic         l_key[2];
    logic         abort_i[2];
    logic         ack[2];
    logic         b_ready[2];
    logic         crst[2];
    logic         done[2];
    logic [2:0]   dbg[2];
    logic [127:0] blk[2];
    logic [127:0] key0;
    logic [255:0] key1;

    int  n_vec;
    int  n_bad;
    bit  chk_on;
    int  acc0 = 0;

    aes_input_loader_if s0();
    aes_input_loader_if s1();

    assign s0.byte_in    = b_in[0];
    assign s0.byte_valid = b_valid[0];
    assign s0.load_key   = l_key[0];
    assign b_ready[0]    = s0.byte_ready;
    assign s1.byte_in    = b_in[1];
    assign s1.byte_valid = b_valid[1];
    assign s1.load_key   = l_key[1];
    assign b_ready[1]    = s1.byte_ready;

    aes_input_loader #(.Nk(4), .Nr(10)) dut128 (
        .clk(clk), .reset(rst_n), .stream(s0), .abort(abort_i[0]), .done_ack(ack[0]),
        .key_out(key0), .block_out(blk[0]), .core_rst(crst[0]), .done(done[0]), .dbg_state(dbg[0])
    );

    aes_input_loader #(.Nk(8), .Nr(14)) dut256 (
        .clk(clk), .reset(rst_n), .stream(s1), .abort(abort_i[1]), .done_ack(ack[1]),
        .key_out(key1), .block_out(blk[1]), .core_rst(crst[1]), .done(done[1]), .dbg_state(dbg[1])
    );

    // ---------------- frame-level reference model ----------------
    typedef struct {
        logic [255:0] key;
        logic [127:0] blk;
        logic [255:0] kacc;
        logic [127:0] pacc;
        int           kn;
        int           pn;
        bit           open;
        bit           kphase;
        bit           running;
        int           rcnt;
        bit           fin;
    } mst_t;

    mst_t ms[2];

    function automatic mst_t model_reset();
        mst_t r;
        r.key = '0; r.blk = '0; r.kacc = '0; r.pacc = '0;
        r.kn = 0; r.pn = 0; r.open = 0; r.kphase = 0;
        r.running = 0; r.rcnt = 0; r.fin = 0;
        return r;
    endfunction

    function automatic mst_t model_next(mst_t s, int nk, logic v, logic [7:0] d,
                                        logic lk, logic ab, logic ak);
        mst_t n = s;
        if (ab) begin
            n.open = 0; n.kn = 0; n.pn = 0; n.running = 0; n.rcnt = 0; n.fin = 0;
        end else if (s.fin) begin
            if (ak) n.fin = 0;
        end else if (s.running) begin
            // Core is done after Nr+1 edges out of reset.
            if (s.rcnt == nk + 6) begin
                n.running = 0;
                n.fin = 1;
            end else begin
                n.rcnt = s.rcnt + 1;
            end
        end else if (v) begin
            if (!s.open) begin
                n.open = 1;
                n.kphase = lk;
            end
            if (n.kphase) begin
                n.kacc = (((s.kn == 0) ? 256'b0 : s.kacc) << 8) | 256'(d);
                n.kn = s.kn + 1;
                if (n.kn == 4 * nk) begin
                    n.key = n.kacc;
                    n.kn = 0;
                    n.kphase = 0;
                end
            end else begin
                n.pacc = (((s.pn == 0) ? 128'b0 : s.pacc) << 8) | 128'(d);
                n.pn = s.pn + 1;
                if (n.pn == 16) begin
                    n.blk = n.pacc;
                    n.pn = 0;
                    n.open = 0;
                    n.running = 1;
                    n.rcnt = 0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) ms[u] <= model_reset();
            else ms[u] <= model_next(ms[u], (u == 0) ? 4 : 8, b_valid[u], b_in[u],
                                     l_key[u], abort_i[u], ack[u]);
        end
    end

    always @(posedge clk) begin
        if (b_valid[0] && b_ready[0]) acc0 <= acc0 + 1;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int u = 0; u < 2; u++) begin
                    chk($sformatf("u%0d byte_ready", u), 256'(b_ready[u]),
                        256'(!(ms[u].running || ms[u].fin)));
                    chk($sformatf("u%0d core_rst", u), 256'(crst[u]),
                        256'(!(ms[u].running || ms[u].fin)));
                    chk($sformatf("u%0d done", u), 256'(done[u]), 256'(ms[u].fin));
                    chk($sformatf("u%0d key_out", u), (u == 0) ? {128'b0, key0} : key1, ms[u].key);
                    chk($sformatf("u%0d block_out", u), 256'(blk[u]), 256'(ms[u].blk));
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    // All driver tasks start and end at negedge+2.
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic send_byte(input int u, input logic [7:0] d, input logic lk, input int gap);
        repeat (gap) begin
            b_valid[u] = 1'b0;
            step();
        end
        b_valid[u] = 1'b1;
        b_in[u]    = d;
        l_key[u]   = lk;
        step();
    endtask

    task automatic send_frame(input int u, input bit wk, input int gmax);
        int nk;
        nk = (u == 0) ? 4 : 8;
        if (wk) begin
            for (int i = 0; i < 4 * nk; i++) send_byte(u, 8'(i), 1'b1, $urandom_range(gmax, 0));
        end
        for (int i = 0; i < 16; i++) send_byte(u, 8'(17 * i), wk, $urandom_range(gmax, 0));
        b_valid[u] = 1'b0;
    endtask

    task automatic wait_done(input int u, input int exp_lat, input string name);
        int k;
        k = 0;
        while (!done[u] && k < 100) begin
            step();
            k++;
        end
        chk(name, 256'(k), 256'(exp_lat));
    endtask

    task automatic ack_pulse(input int u);
        ack[u] = 1'b1;
        step();
        ack[u] = 1'b0;
    endtask

    int base;

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        chk_on = 0;
        for (int u = 0; u < 2; u++) begin
            b_in[u] = '0; b_valid[u] = 0; l_key[u] = 0; abort_i[u] = 0; ack[u] = 0;
        end
        rst_n = 1'b0;
        fork
            compare_loop();
        join_none
        repeat (3) step();

        for (int u = 0; u < 2; u++) begin
            chk($sformatf("reset u%0d byte_ready", u), 256'(b_ready[u]), 256'd1);
            chk($sformatf("reset u%0d core_rst", u), 256'(crst[u]), 256'd1);
            chk($sformatf("reset u%0d done", u), 256'(done[u]), 256'd0);
            chk($sformatf("reset u%0d block_out", u), 256'(blk[u]), 256'd0);
        end
        chk("reset key_out u0", {128'b0, key0}, 256'd0);
        chk("reset key_out u1", key1, 256'd0);
        rst_n  = 1'b1;
        chk_on = 1;
        step();

        // AES-256 frame, back-to-back bytes
        send_frame(1, 1'b1, 0);
        chk("aes256 key_out", key1, K256);
        chk("aes256 block_out", 256'(blk[1]), 256'(PT));
        chk("aes256 core_rst at T", 256'(crst[1]), 256'd0);
        wait_done(1, 15, "aes256 done latency");
        ack_pulse(1);
        chk("aes256 ready after ack", 256'(b_ready[1]), 256'd1);

        // Abort together with key byte 9
        for (int i = 0; i < 9; i++) send_byte(0, 8'(i), 1'b1, 0);
        b_valid[0] = 1'b1;
        b_in[0]    = 8'd9;
        abort_i[0] = 1'b1;
        step();
        abort_i[0] = 1'b0;
        b_valid[0] = 1'b0;
        chk("abort key_out", {128'b0, key0}, 256'd0);
        chk("abort byte_ready", 256'(b_ready[0]), 256'd1);
        chk("abort core_rst", 256'(crst[0]), 256'd1);

        // AES-128 frame after the abort
        send_frame(0, 1'b1, 0);
        chk("aes128 key_out", {128'b0, key0}, 256'(K128));
        chk("aes128 block_out", 256'(blk[0]), 256'(PT));
        chk("aes128 core_rst at T", 256'(crst[0]), 256'd0);
        wait_done(0, 11, "aes128 done latency");

        // done_ack held low for 20 cycles while bytes are offered
        base       = acc0;
        b_valid[0] = 1'b1;
        b_in[0]    = 8'haa;
        l_key[0]   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold done", 256'(done[0]), 256'd1);
            chk("hold block_out", 256'(blk[0]), 256'(PT));
            chk("hold byte_ready", 256'(b_ready[0]), 256'd0);
        end
        chk("hold bytes consumed", 256'(acc0 - base), 256'd0);
        b_valid[0] = 1'b0;
        ack_pulse(0);
        chk("ack done cleared", 256'(done[0]), 256'd0);
        chk("ack byte_ready", 256'(b_ready[0]), 256'd1);

        // Key reuse with random gaps, done_ack held high (back-to-back)
        ack[0] = 1'b1;
        base   = acc0;
        send_frame(0, 1'b0, 3);
        chk("reuse bytes accepted", 256'(acc0 - base), 256'd16);
        chk("reuse key_out", {128'b0, key0}, 256'(K128));
        chk("reuse block_out", 256'(blk[0]), 256'(PT));
        wait_done(0, 11, "reuse done latency");
        step();
        chk("b2b done one cycle", 256'(done[0]), 256'd0);
        chk("b2b byte_ready", 256'(b_ready[0]), 256'd1);
        ack[0] = 1'b0;

        // Reset five cycles into RUN
        send_frame(0, 1'b1, 0);
        repeat (5) step();
        chk("pre-reset core_rst", 256'(crst[0]), 256'd0);
        rst_n = 1'b0;
        #1;
        chk("async reset core_rst", 256'(crst[0]), 256'd1);
        chk("async reset done", 256'(done[0]), 256'd0);
        chk("async reset block_out", 256'(blk[0]), 256'd0);
        chk("async reset key_out", {128'b0, key0}, 256'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("post-reset byte_ready", 256'(b_ready[0]), 256'd1);
        send_frame(0, 1'b1, 1);
        chk("post-reset key_out", {128'b0, key0}, 256'(K128));
        chk("post-reset block_out", 256'(blk[0]), 256'(PT));
        wait_done(0, 11, "post-reset done latency");
        ack_pulse(0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
